// File: rtl/tl_ul_rr_arbiter.sv
// Two-requester TL-UL A-channel round-robin arbiter with D-channel return routing.
// Per-requester inflight counters cap outstanding requests; a stalled grant is held until accepted.
module tl_ul_rr_arbiter #(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        a0_valid,
    output logic        a0_ready,
    input  logic [2:0]  a0_opcode,
    input  logic [2:0]  a0_param,
    input  logic [2:0]  a0_size,
    input  logic [1:0]  a0_source,
    input  logic [29:0] a0_address,
    input  logic [3:0]  a0_mask,
    input  logic [31:0] a0_data,

    input  logic        a1_valid,
    output logic        a1_ready,
    input  logic [2:0]  a1_opcode,
    input  logic [2:0]  a1_param,
    input  logic [2:0]  a1_size,
    input  logic [1:0]  a1_source,
    input  logic [29:0] a1_address,
    input  logic [3:0]  a1_mask,
    input  logic [31:0] a1_data,

    output logic        a_valid,
    input  logic        a_ready,
    output logic [2:0]  a_opcode,
    output logic [2:0]  a_param,
    output logic [2:0]  a_size,
    output logic [2:0]  a_source,
    output logic [29:0] a_address,
    output logic [3:0]  a_mask,
    output logic [31:0] a_data,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [2:0]  d_opcode,
    input  logic [1:0]  d_param,
    input  logic [2:0]  d_size,
    input  logic [2:0]  d_source,
    input  logic        d_sink,
    input  logic        d_denied,
    input  logic [31:0] d_data,
    input  logic        d_corrupt,

    output logic        d0_valid,
    input  logic        d0_ready,
    output logic [2:0]  d0_opcode,
    output logic [1:0]  d0_param,
    output logic [2:0]  d0_size,
    output logic [1:0]  d0_source,
    output logic        d0_sink,
    output logic        d0_denied,
    output logic [31:0] d0_data,
    output logic        d0_corrupt,

    output logic        d1_valid,
    input  logic        d1_ready,
    output logic [2:0]  d1_opcode,
    output logic [1:0]  d1_param,
    output logic [2:0]  d1_size,
    output logic [1:0]  d1_source,
    output logic        d1_sink,
    output logic        d1_denied,
    output logic [31:0] d1_data,
    output logic        d1_corrupt,

    output logic        err_unexpected_d
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t     state_q, state_d;
    logic       gsel_q, gsel_d;
    logic       ptr_q, ptr_d;
    logic       err_q, err_d;

    logic       grant_vld;
    logic       grant;
    logic       a_fire;
    logic       d_sel;
    logic       d_fire;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] elig;
    logic [1:0] unexp;

    assign req_valid = {a1_valid, a0_valid};

    always_comb begin
        grant_vld = 1'b0;
        grant     = 1'b0;
        state_d   = state_q;
        gsel_d    = gsel_q;
        case (state_q)
            IDLE: begin
                if (elig[0] && elig[1]) begin
                    grant_vld = 1'b1;
                    grant     = ~ptr_q;
                end else if (elig[0] || elig[1]) begin
                    grant_vld = 1'b1;
                    grant     = elig[1];
                end
                if (grant_vld && !a_ready) begin
                    state_d = HOLD;
                    gsel_d  = grant;
                end
            end
            HOLD: begin
                // A stalled grant stays put even if the requester hits its inflight cap.
                grant_vld = 1'b1;
                grant     = gsel_q;
                if (a_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign a_valid  = grant_vld & ~reset;
    assign a_fire   = a_valid & a_ready;
    assign a0_ready = a_ready & grant_vld & ~grant & ~reset;
    assign a1_ready = a_ready & grant_vld &  grant & ~reset;
    assign req_ready = {a1_ready, a0_ready};

    assign a_opcode  = grant ? a1_opcode  : a0_opcode;
    assign a_param   = grant ? a1_param   : a0_param;
    assign a_size    = grant ? a1_size    : a0_size;
    assign a_source  = {grant, (grant ? a1_source : a0_source)};
    assign a_address = grant ? a1_address : a0_address;
    assign a_mask    = grant ? a1_mask    : a0_mask;
    assign a_data    = grant ? a1_data    : a0_data;

    assign d_sel    = d_source[2];
    assign d0_valid = d_valid & ~d_sel & ~reset;
    assign d1_valid = d_valid &  d_sel & ~reset;
    assign d_ready  = (d_sel ? d1_ready : d0_ready) & ~reset;
    assign d_fire   = d_valid & d_ready;

    assign d0_opcode  = d_opcode;
    assign d0_param   = d_param;
    assign d0_size    = d_size;
    assign d0_source  = d_source[1:0];
    assign d0_sink    = d_sink;
    assign d0_denied  = d_denied;
    assign d0_data    = d_data;
    assign d0_corrupt = d_corrupt;
    assign d1_opcode  = d_opcode;
    assign d1_param   = d_param;
    assign d1_size    = d_size;
    assign d1_source  = d_source[1:0];
    assign d1_sink    = d_sink;
    assign d1_denied  = d_denied;
    assign d1_data    = d_data;
    assign d1_corrupt = d_corrupt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic [2:0] cnt_q, cnt_d;
            logic       inc, dec;

            assign inc       = req_valid[gi] & req_ready[gi];
            assign dec       = d_fire & (d_sel == 1'(gi));
            assign elig[gi]  = req_valid[gi] & (cnt_q < MAX_CNT);
            assign unexp[gi] = dec & (cnt_q == 3'd0);

            // A response with nothing outstanding is flagged and never underflows.
            always_comb begin
                cnt_d = cnt_q;
                if (inc && !dec) begin
                    cnt_d = cnt_q + 3'd1;
                end else if (dec && !inc && cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_q <= 3'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign ptr_d = a_fire ? grant : ptr_q;
    assign err_d = err_q | (|unexp);
    assign err_unexpected_d = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            gsel_q  <= 1'b0;
            ptr_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gsel_q  <= gsel_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

endmodule
